// File: rtl/dm_unit.sv
// Data-memory stage for the 5-stage RISC-V pipeline.
// Sits behind the CPU EX/MEM registers. It steers store bytes into the
// right lanes, sign- or zero-extends loads, and rejects misaligned or
// out-of-range accesses. The first faulting store is held in a sticky
// record, and committed stores are counted with saturation.
// Load data is combinational from addr/dm_type, so the CPU samples it
// into MEM/WB on the next rising edge.

module dm_unit #(
    parameter int DEPTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_w,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [2:0]       dm_type,
    output logic [31:0]      rdata,
    output logic             fault,
    output logic [31:0]      fault_addr,
    output logic [1:0]       fault_code,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] store_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Access-size encoding used internally after dm_type decode
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // dm_type codes as driven by the CPU
    localparam logic [2:0] DT_WORD  = 3'b000;
    localparam logic [2:0] DT_HALF  = 3'b001;
    localparam logic [2:0] DT_HALFU = 3'b010;
    localparam logic [2:0] DT_BYTE  = 3'b011;
    localparam logic [2:0] DT_BYTEU = 3'b100;

    // Sign- or zero-extend a halfword to 32 bits
    function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
        logic [31:0] r;
        if (uns) begin
            r = {16'h0000, h};
        end else begin
            r = {{16{h[15]}}, h};
        end
        return r;
    endfunction

    // Sign- or zero-extend a byte to 32 bits
    function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
        logic [31:0] r;
        if (uns) begin
            r = {24'h000000, b};
        end else begin
            r = {{24{b[7]}}, b};
        end
        return r;
    endfunction

    // Byte-lane enables for a store of the given size at the given offset
    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = 4'b0011 << off;
            SZ_BYTE: be = 4'b0001 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    logic [31:0]      mem_r [DEPTH];

    logic [1:0]       size_s;
    logic             uns_s;
    logic             mis_s;
    logic             oor_s;
    logic             bad_s;
    logic             we_s;
    logic             fault_ev_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_word_s;
    logic [15:0]      rd_half_s;
    logic [7:0]       rd_byte_s;
    logic [31:0]      rdata_s;
    logic [3:0]       be_s;
    logic [31:0]      wlane_s;

    logic             fault_r;
    logic [31:0]      fault_addr_r;
    logic [1:0]       fault_code_r;
    logic [CNT_W-1:0] store_cnt_r;

    // Decode dm_type into size and signedness; reserved codes behave as word
    always_comb begin
        size_s = SZ_WORD;
        uns_s  = 1'b0;
        case (dm_type)
            DT_WORD:  begin size_s = SZ_WORD; uns_s = 1'b0; end
            DT_HALF:  begin size_s = SZ_HALF; uns_s = 1'b0; end
            DT_HALFU: begin size_s = SZ_HALF; uns_s = 1'b1; end
            DT_BYTE:  begin size_s = SZ_BYTE; uns_s = 1'b0; end
            DT_BYTEU: begin size_s = SZ_BYTE; uns_s = 1'b1; end
            default:  begin size_s = SZ_WORD; uns_s = 1'b0; end
        endcase
    end

    // Alignment and range checks on the current access
    always_comb begin
        mis_s = 1'b0;
        if (size_s == SZ_WORD) begin
            mis_s = (addr[1:0] != 2'b00);
        end else if (size_s == SZ_HALF) begin
            mis_s = addr[0];
        end else begin
            mis_s = 1'b0;
        end
        oor_s      = ({2'b00, addr[31:2]} >= 32'(DEPTH));
        bad_s      = mis_s | oor_s;
        we_s       = mem_w & ~bad_s;
        fault_ev_s = mem_w & bad_s;
        idx_s      = addr[IDX_W+1:2];
    end

    // Combinational load path: lane select, extension, zero on a bad access
    always_comb begin
        rd_word_s = mem_r[idx_s];
        if (addr[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
        case (addr[1:0])
            2'b00:   rd_byte_s = rd_word_s[7:0];
            2'b01:   rd_byte_s = rd_word_s[15:8];
            2'b10:   rd_byte_s = rd_word_s[23:16];
            2'b11:   rd_byte_s = rd_word_s[31:24];
            default: rd_byte_s = rd_word_s[7:0];
        endcase
        if (bad_s) begin
            rdata_s = 32'h0000_0000;
        end else begin
            case (size_s)
                SZ_WORD: rdata_s = rd_word_s;
                SZ_HALF: rdata_s = ext16(rd_half_s, uns_s);
                SZ_BYTE: rdata_s = ext8(rd_byte_s, uns_s);
                default: rdata_s = rd_word_s;
            endcase
        end
    end

    // Store lane data: right-aligned wdata replicated across the word
    always_comb begin
        be_s = byte_en(size_s, addr[1:0]);
        case (size_s)
            SZ_WORD: wlane_s = wdata;
            SZ_HALF: wlane_s = {2{wdata[15:0]}};
            SZ_BYTE: wlane_s = {4{wdata[7:0]}};
            default: wlane_s = wdata;
        endcase
    end

    // Array write; a store seen while reset is asserted is dropped, contents are kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // The array holds its contents through reset.
        end else if (we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    // Saturating count of committed stores
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_cnt_r <= '0;
        end else if (we_s && (store_cnt_r != {CNT_W{1'b1}})) begin
            store_cnt_r <= store_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky fault record: first faulting store wins, clear beats a new event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r      <= 1'b0;
            fault_addr_r <= 32'h0000_0000;
            fault_code_r <= 2'b00;
        end else if (fault_clr) begin
            fault_r      <= 1'b0;
            fault_addr_r <= 32'h0000_0000;
            fault_code_r <= 2'b00;
        end else if (fault_ev_s && !fault_r) begin
            fault_r      <= 1'b1;
            fault_addr_r <= addr;
            fault_code_r <= {oor_s, mis_s};
        end
    end

    assign rdata      = rdata_s;
    assign fault      = fault_r;
    assign fault_addr = fault_addr_r;
    assign fault_code = fault_code_r;
    assign store_cnt  = store_cnt_r;

endmodule

// File: tb/tb_dm_unit.sv
// Scoreboard bench for dm_unit. The stimulus process drives directed accesses and
// queues hand-computed expectations. A negedge monitor pops them and compares.
// A second instance with a 2-bit counter shares the inputs so that counter
// saturation is exercised alongside the main instance.

module tb_dm_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_type;
    logic        fault_clr;

    logic [31:0] rdata;
    logic        fault;
    logic [31:0] fault_addr;
    logic [1:0]  fault_code;
    logic [15:0] store_cnt;

    logic [31:0] rdata2;
    logic        fault2;
    logic [31:0] fault_addr2;
    logic [1:0]  fault_code2;
    logic [1:0]  store_cnt2;

    localparam int C_RDATA = 0;
    localparam int C_FAULT = 1;
    localparam int C_FADDR = 2;
    localparam int C_FCODE = 3;
    localparam int C_CNT   = 4;
    localparam int C_CNT2  = 5;

    typedef struct {
        int          code;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    int checks;
    int errors;
    bit done;

    dm_unit #(.DEPTH(128), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_w(mem_w), .addr(addr), .wdata(wdata),
        .dm_type(dm_type), .rdata(rdata), .fault(fault), .fault_addr(fault_addr),
        .fault_code(fault_code), .fault_clr(fault_clr), .store_cnt(store_cnt)
    );

    dm_unit #(.DEPTH(128), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_w(mem_w), .addr(addr), .wdata(wdata),
        .dm_type(dm_type), .rdata(rdata2), .fault(fault2), .fault_addr(fault_addr2),
        .fault_code(fault_code2), .fault_clr(fault_clr), .store_cnt(store_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string name_of(input int code);
        case (code)
            C_RDATA: return "rdata";
            C_FAULT: return "fault";
            C_FADDR: return "fault_addr";
            C_FCODE: return "fault_code";
            C_CNT:   return "store_cnt";
            C_CNT2:  return "store_cnt_w2";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int code, input logic [31:0] v);
        exp_t e;
        e.code = code;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Drive one access shortly after the rising edge
    task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] t, input logic clr);
        @(posedge clk);
        #1;
        mem_w     = mw;
        addr      = a;
        wdata     = wd;
        dm_type   = t;
        fault_clr = clr;
    endtask

    task automatic push_rec(input logic f, input logic [31:0] fa, input logic [1:0] fc);
        push(C_FAULT, {31'h0, f});
        push(C_FADDR, fa);
        push(C_FCODE, {30'h0, fc});
    endtask

    // Monitor: compare every queued expectation against the DUT at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.code)
                C_RDATA: mon_act = rdata;
                C_FAULT: mon_act = {31'h0, fault};
                C_FADDR: mon_act = fault_addr;
                C_FCODE: mon_act = {30'h0, fault_code};
                C_CNT:   mon_act = {16'h0, store_cnt};
                C_CNT2:  mon_act = {30'h0, store_cnt2};
                default: mon_act = 32'hxxxx_xxxx;
            endcase
            checks = checks + 1;
            if (mon_act !== mon_e.val) begin
                errors = errors + 1;
                $display("FAIL %s at %0t: got %h expected %h", name_of(mon_e.code), $time, mon_act, mon_e.val);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: stimulus did not complete");
            $fatal(1, "timeout");
        end
    end

    initial begin
        checks = 0; errors = 0; done = 1'b0;
        rst_n = 1'b0; mem_w = 1'b0; addr = 32'h0; wdata = 32'h0; dm_type = 3'b000; fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Reset state
        cyc(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        push_rec(1'b0, 32'h0, 2'b00);
        push(C_CNT, 32'd0);
        push(C_CNT2, 32'd0);

        // Word store then word load
        cyc(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 1'b0);
        cyc(1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
        push(C_RDATA, 32'hDEADBEEF);
        push(C_CNT, 32'd1);
        push(C_CNT2, 32'd1);

        // Byte store at 0x21 and extended loads
        cyc(1'b1, 32'h20, 32'h0, 3'b000, 1'b0);
        cyc(1'b1, 32'h21, 32'h80, 3'b011, 1'b0);
        cyc(1'b0, 32'h20, 32'h0, 3'b000, 1'b0);
        push(C_RDATA, 32'h00008000);
        push(C_CNT, 32'd3);
        push(C_CNT2, 32'd3);
        cyc(1'b0, 32'h21, 32'h0, 3'b011, 1'b0);
        push(C_RDATA, 32'hFFFFFF80);
        cyc(1'b0, 32'h21, 32'h0, 3'b100, 1'b0);
        push(C_RDATA, 32'h00000080);

        // Halfword lane select and extension
        cyc(1'b1, 32'h10, 32'h1234ABCD, 3'b000, 1'b0);
        cyc(1'b0, 32'h12, 32'h0, 3'b001, 1'b0);
        push(C_RDATA, 32'h00001234);
        push(C_CNT, 32'd4);
        push(C_CNT2, 32'd3);
        cyc(1'b0, 32'h10, 32'h0, 3'b001, 1'b0);
        push(C_RDATA, 32'hFFFFABCD);
        cyc(1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        push(C_RDATA, 32'h0000ABCD);

        // Half and byte stores touch only their lanes
        cyc(1'b1, 32'h12, 32'h00008765, 3'b001, 1'b0);
        cyc(1'b0, 32'h12, 32'h0, 3'b001, 1'b0);
        push(C_RDATA, 32'hFFFF8765);
        cyc(1'b1, 32'h13, 32'h0000005A, 3'b011, 1'b0);
        cyc(1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
        push(C_RDATA, 32'h5A65ABCD);
        push(C_CNT, 32'd6);

        // Misaligned word store: no write, fault captured
        cyc(1'b1, 32'h13, 32'hFFFFFFFF, 3'b000, 1'b0);
        cyc(1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
        push(C_RDATA, 32'h5A65ABCD);
        push_rec(1'b1, 32'h13, 2'b01);
        push(C_CNT, 32'd6);

        // Out-of-range store while faulted: record held
        cyc(1'b1, 32'h200, 32'h1, 3'b000, 1'b0);
        cyc(1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
        push_rec(1'b1, 32'h13, 2'b01);
        push(C_CNT, 32'd6);

        // Clear beats a simultaneous event; repeated event captures both causes
        cyc(1'b1, 32'h201, 32'h0, 3'b001, 1'b1);
        cyc(1'b1, 32'h201, 32'h0, 3'b001, 1'b0);
        push_rec(1'b0, 32'h0, 2'b00);
        cyc(1'b0, 32'h10, 32'h0, 3'b000, 1'b0);
        push_rec(1'b1, 32'h201, 2'b11);
        push(C_CNT, 32'd6);

        // Last valid word is writable; reads that fail the checks return 0
        cyc(1'b1, 32'h1FC, 32'hCAFEF00D, 3'b000, 1'b0);
        cyc(1'b0, 32'h1FC, 32'h0, 3'b000, 1'b0);
        push(C_RDATA, 32'hCAFEF00D);
        push(C_CNT, 32'd7);
        push_rec(1'b1, 32'h201, 2'b11);
        cyc(1'b0, 32'h200, 32'h0, 3'b100, 1'b0);
        push(C_RDATA, 32'h0);
        cyc(1'b0, 32'h11, 32'h0, 3'b001, 1'b0);
        push(C_RDATA, 32'h0);

        // Reserved dm_type acts as word
        cyc(1'b1, 32'h30, 32'h11112222, 3'b101, 1'b0);
        cyc(1'b0, 32'h30, 32'h0, 3'b111, 1'b0);
        push(C_RDATA, 32'h11112222);
        push(C_CNT, 32'd8);
        cyc(1'b0, 32'h31, 32'h0, 3'b101, 1'b0);
        push(C_RDATA, 32'h0);

        // Async reset in the middle of a store
        cyc(1'b1, 32'h30, 32'hFFFFFFFF, 3'b000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        push_rec(1'b0, 32'h0, 2'b00);
        push(C_CNT, 32'd0);
        push(C_CNT2, 32'd0);
        cyc(1'b0, 32'h30, 32'h0, 3'b000, 1'b0);
        #1 rst_n = 1'b1;
        push(C_RDATA, 32'h11112222);
        push(C_CNT, 32'd0);

        // Four good stores: narrow counter saturates at 3
        cyc(1'b1, 32'h40, 32'h1, 3'b000, 1'b0);
        cyc(1'b1, 32'h44, 32'h2, 3'b000, 1'b0);
        cyc(1'b1, 32'h48, 32'h3, 3'b000, 1'b0);
        cyc(1'b1, 32'h4C, 32'h4, 3'b000, 1'b0);
        cyc(1'b0, 32'h4C, 32'h0, 3'b000, 1'b0);
        push(C_RDATA, 32'h4);
        push(C_CNT, 32'd4);
        push(C_CNT2, 32'd3);

        cyc(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
